// File: rtl/axil_memory_arbiter_pkg.sv
// Shared types and constants for the AXI-Lite memory arbiter.
package axil_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_RESP = 3'd4
   } arb_state_e;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Index width for an N-entry selector; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axil_memory_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after ptr_i
// (wrapping) wins, so the entry at ptr_i itself has the lowest priority.
module rr_arbiter
   import axil_arbiter_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          any_req_o
);

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      int            cand;
      logic [IW-1:0] cand_idx;
      cand        = 0;
      cand_idx    = '0;
      grant_o     = '0;
      grant_idx_o = '0;
      any_req_o   = |req_i;
      for (int off = N; off >= 1; off--) begin
         cand = int'(ptr_i) + off;
         if (cand >= N) cand = cand - N;
         cand_idx = IW'(cand);
         if (req_i[cand_idx]) begin
            grant_o           = '0;
            grant_o[cand_idx] = 1'b1;
            grant_idx_o       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/axil_memory_arbiter.sv
// Shares one AXI-Lite memory port between NUM_MASTERS AXI-Lite masters.
// One transaction in flight at a time, round-robin between masters, and a
// read wins over a write from the same master.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no transaction; arbitrate and register the grant
//  RD_ADDR | forward granted AR channel to memory
//  RD_DATA | route memory R channel back to the granted master
//  WR_ADDR | forward AW and W in parallel, each dropped once accepted
//  WR_RESP | route memory B channel back to the granted master
module axil_memory_arbiter
   import axil_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   parameter  int ADDR_WIDTH  = 32,
   parameter  int DATA_WIDTH  = 16,
   localparam int STRB_WIDTH  = DATA_WIDTH / 8,
   localparam int IW          = idx_width(NUM_MASTERS)
) (
   input  logic                                   aclk,
   input  logic                                   aresetn,
   // per-master slave ports
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [NUM_MASTERS-1:0][2:0]            s_axil_awprot,
   input  logic [NUM_MASTERS-1:0]                 s_axil_awvalid,
   output logic [NUM_MASTERS-1:0]                 s_axil_awready,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [NUM_MASTERS-1:0][STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic [NUM_MASTERS-1:0]                 s_axil_wvalid,
   output logic [NUM_MASTERS-1:0]                 s_axil_wready,
   output logic [NUM_MASTERS-1:0][1:0]            s_axil_bresp,
   output logic [NUM_MASTERS-1:0]                 s_axil_bvalid,
   input  logic [NUM_MASTERS-1:0]                 s_axil_bready,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [NUM_MASTERS-1:0][2:0]            s_axil_arprot,
   input  logic [NUM_MASTERS-1:0]                 s_axil_arvalid,
   output logic [NUM_MASTERS-1:0]                 s_axil_arready,
   output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_axil_rdata,
   output logic [NUM_MASTERS-1:0][1:0]            s_axil_rresp,
   output logic [NUM_MASTERS-1:0]                 s_axil_rvalid,
   input  logic [NUM_MASTERS-1:0]                 s_axil_rready,
   // single master port toward the memory
   output logic [ADDR_WIDTH-1:0]                  m_axil_awaddr,
   output logic [2:0]                             m_axil_awprot,
   output logic                                   m_axil_awvalid,
   input  logic                                   m_axil_awready,
   output logic [DATA_WIDTH-1:0]                  m_axil_wdata,
   output logic [STRB_WIDTH-1:0]                  m_axil_wstrb,
   output logic                                   m_axil_wvalid,
   input  logic                                   m_axil_wready,
   input  logic [1:0]                             m_axil_bresp,
   input  logic                                   m_axil_bvalid,
   output logic                                   m_axil_bready,
   output logic [ADDR_WIDTH-1:0]                  m_axil_araddr,
   output logic [2:0]                             m_axil_arprot,
   output logic                                   m_axil_arvalid,
   input  logic                                   m_axil_arready,
   input  logic [DATA_WIDTH-1:0]                  m_axil_rdata,
   input  logic [1:0]                             m_axil_rresp,
   input  logic                                   m_axil_rvalid,
   output logic                                   m_axil_rready
);

   arb_state_e             state_q, state_d;
   logic [IW-1:0]          grant_q, grant_d;
   logic [NUM_MASTERS-1:0] grant_oh_q, grant_oh_d;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] arb_onehot;
   logic [IW-1:0]          arb_idx;
   logic                   any_req;
   logic                   ar_hs, r_hs, aw_hs, w_hs, b_hs;

   // A write only competes once both its address and data are offered.
   assign req = s_axil_arvalid | (s_axil_awvalid & s_axil_wvalid);

   rr_arbiter #(.N(NUM_MASTERS)) u_rr_arbiter (
      .req_i       (req),
      .ptr_i       (rr_ptr_q),
      .grant_o     (arb_onehot),
      .grant_idx_o (arb_idx),
      .any_req_o   (any_req)
   );

   assign ar_hs = m_axil_arvalid & m_axil_arready;
   assign r_hs  = m_axil_rvalid  & m_axil_rready;
   assign aw_hs = m_axil_awvalid & m_axil_awready;
   assign w_hs  = m_axil_wvalid  & m_axil_wready;
   assign b_hs  = m_axil_bvalid  & m_axil_bready;

   // Request-side payload always follows the registered grant.
   always_comb begin
      m_axil_araddr = s_axil_araddr[grant_q];
      m_axil_arprot = s_axil_arprot[grant_q];
      m_axil_awaddr = s_axil_awaddr[grant_q];
      m_axil_awprot = s_axil_awprot[grant_q];
      m_axil_wdata  = s_axil_wdata[grant_q];
      m_axil_wstrb  = s_axil_wstrb[grant_q];
   end

   // Handshake routing; everything outside the active channel stays at zero.
   always_comb begin
      m_axil_arvalid = 1'b0;
      m_axil_awvalid = 1'b0;
      m_axil_wvalid  = 1'b0;
      m_axil_rready  = 1'b0;
      m_axil_bready  = 1'b0;
      s_axil_arready = '0;
      s_axil_awready = '0;
      s_axil_wready  = '0;
      s_axil_rvalid  = '0;
      s_axil_bvalid  = '0;
      s_axil_rdata   = '0;
      s_axil_rresp   = {NUM_MASTERS{AXI_RESP_OKAY}};
      s_axil_bresp   = {NUM_MASTERS{AXI_RESP_OKAY}};
      case (state_q)
         RD_ADDR: begin
            m_axil_arvalid = s_axil_arvalid[grant_q];
            s_axil_arready = grant_oh_q & {NUM_MASTERS{m_axil_arready}};
         end
         RD_DATA: begin
            s_axil_rvalid          = grant_oh_q & {NUM_MASTERS{m_axil_rvalid}};
            s_axil_rdata[grant_q]  = m_axil_rdata;
            s_axil_rresp[grant_q]  = m_axil_rresp;
            m_axil_rready          = s_axil_rready[grant_q];
         end
         WR_ADDR: begin
            m_axil_awvalid = s_axil_awvalid[grant_q] & ~aw_done_q;
            m_axil_wvalid  = s_axil_wvalid[grant_q]  & ~w_done_q;
            s_axil_awready = grant_oh_q & {NUM_MASTERS{m_axil_awready & ~aw_done_q}};
            s_axil_wready  = grant_oh_q & {NUM_MASTERS{m_axil_wready & ~w_done_q}};
         end
         WR_RESP: begin
            s_axil_bvalid         = grant_oh_q & {NUM_MASTERS{m_axil_bvalid}};
            s_axil_bresp[grant_q] = m_axil_bresp;
            m_axil_bready         = s_axil_bready[grant_q];
         end
         default: ;
      endcase
   end

   // Next-state, grant capture and round-robin pointer update.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_oh_d = grant_oh_q;
      rr_ptr_d   = rr_ptr_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d    = arb_idx;
               grant_oh_d = arb_onehot;
               state_d    = s_axil_arvalid[arb_idx] ? RD_ADDR : WR_ADDR;
            end
         end
         RD_ADDR: begin
            if (ar_hs) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (r_hs) begin
               rr_ptr_d = grant_q;
               state_d  = IDLE;
            end
         end
         WR_ADDR: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               rr_ptr_d = grant_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset leaves master 0 as the first winner.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         rr_ptr_q   <= IW'(NUM_MASTERS - 1);
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_oh_q <= grant_oh_d;
         rr_ptr_q   <= rr_ptr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

endmodule

// File: tb/tb_axil_memory_arbiter.sv
// Scoreboard bench for axil_memory_arbiter: directed master traffic, a small
// AXI-Lite memory model, and a negedge monitor popping expected transfers.
module tb_axil_memory_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 16;
   localparam int SW = 2;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   logic [NM-1:0][AW-1:0] s_axil_awaddr, s_axil_araddr;
   logic [NM-1:0][2:0]    s_axil_awprot, s_axil_arprot;
   logic [NM-1:0]         s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
   logic [NM-1:0][DW-1:0] s_axil_wdata, s_axil_rdata;
   logic [NM-1:0][SW-1:0] s_axil_wstrb;
   logic [NM-1:0][1:0]    s_axil_bresp, s_axil_rresp;
   logic [NM-1:0]         s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
   logic [NM-1:0]         s_axil_rvalid, s_axil_rready;
   logic [AW-1:0]         m_axil_awaddr, m_axil_araddr;
   logic [2:0]            m_axil_awprot, m_axil_arprot;
   logic                  m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
   logic [DW-1:0]         m_axil_wdata, m_axil_rdata;
   logic [SW-1:0]         m_axil_wstrb;
   logic [1:0]            m_axil_bresp, m_axil_rresp;
   logic                  m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
   logic                  m_axil_rvalid, m_axil_rready;

   axil_memory_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
      .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
      .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct packed {
      logic [7:0]  m;
      logic [31:0] a;   // address, or 1 = write / 0 = read in q_done
      logic [15:0] d;
   } exp_t;

   exp_t q_ar[$], q_aw[$], q_w[$], q_r[$], q_done[$];
   int   ar_cyc[$];
   int   last_aw_cyc = 0;
   int   last_w_cyc = 0;

   logic [15:0] mem [0:4095];

   function automatic logic [15:0] pat(input logic [31:0] addr);
      return 16'hA000 ^ addr[15:0];
   endfunction

   function automatic logic [31:0] idx_of(input logic [NM-1:0] v);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      for (int i = NM - 1; i >= 0; i--) if (v[i]) r = 32'(i);
      return r;
   endfunction

   function automatic exp_t mk(input int m, input logic [31:0] a, input logic [15:0] d);
      exp_t e;
      e.m = 8'(m);
      e.a = a;
      e.d = d;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=none required=event", name);
   endtask

   function automatic logic [14:0] all_ctrl_outs();
      return {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid,
              m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready};
   endfunction

   // Monitor: every handshake the DUT presents pops and checks one expectation.
   always @(negedge aclk) begin
      logic [NM-1:0] act;
      exp_t e;
      cyc++;
      if (aresetn) begin
         act = s_axil_arready | s_axil_awready | s_axil_wready | s_axil_rvalid | s_axil_bvalid;
         if (act != '0) chk("single_master_active", 32'($onehot0(act)), 32'd1);
         if (m_axil_arvalid && m_axil_arready) begin
            ar_cyc.push_back(cyc);
            if (q_ar.size() == 0) fail_now("ar_unexpected");
            else begin
               e = q_ar.pop_front();
               chk("ar_master", idx_of(s_axil_arready), 32'(e.m));
               chk("ar_addr", m_axil_araddr, e.a);
            end
         end
         if (m_axil_awvalid && m_axil_awready) begin
            last_aw_cyc = cyc;
            if (q_aw.size() == 0) fail_now("aw_unexpected");
            else begin
               e = q_aw.pop_front();
               chk("aw_master", idx_of(s_axil_awready), 32'(e.m));
               chk("aw_addr", m_axil_awaddr, e.a);
            end
         end
         if (m_axil_wvalid && m_axil_wready) begin
            last_w_cyc = cyc;
            if (q_w.size() == 0) fail_now("w_unexpected");
            else begin
               e = q_w.pop_front();
               chk("w_master", idx_of(s_axil_wready), 32'(e.m));
               chk("w_data", 32'(m_axil_wdata), 32'(e.d));
            end
         end
         for (int i = 0; i < NM; i++) begin
            if (s_axil_rvalid[i] && s_axil_rready[i]) begin
               if (q_r.size() == 0 || q_done.size() == 0) fail_now("r_unexpected");
               else begin
                  e = q_r.pop_front();
                  chk("r_master", 32'(i), 32'(e.m));
                  chk("r_data", 32'(s_axil_rdata[i]), 32'(e.d));
                  e = q_done.pop_front();
                  chk("order_master", 32'(i), 32'(e.m));
                  chk("order_is_write", 32'd0, e.a);
               end
            end
            if (s_axil_bvalid[i] && s_axil_bready[i]) begin
               if (q_done.size() == 0) fail_now("b_unexpected");
               else begin
                  e = q_done.pop_front();
                  chk("order_master", 32'(i), 32'(e.m));
                  chk("order_is_write", 32'd1, e.a);
                  chk("b_resp", 32'(s_axil_bresp[i]), 32'd0);
               end
            end
         end
      end
   end

   // Memory model: accepts W before AW, answers reads one cycle after AR.
   initial begin
      logic        ar_hs, aw_hs, w_hs, r_hs, b_hs, aw_got, w_got;
      logic [31:0] ara, awa;
      logic [15:0] wd;
      logic [1:0]  ws;
      for (int i = 0; i < 4096; i++) mem[i] = pat(32'(i * 2));
      mem[12'h080] = 16'hBEEF;
      aw_got = 1'b0; w_got = 1'b0; ara = '0; awa = '0; wd = '0; ws = '0;
      m_axil_arready = 1'b1; m_axil_awready = 1'b0; m_axil_wready = 1'b1;
      m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00;
      m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
      forever begin
         @(negedge aclk);
         ar_hs = m_axil_arvalid & m_axil_arready;
         aw_hs = m_axil_awvalid & m_axil_awready;
         w_hs  = m_axil_wvalid  & m_axil_wready;
         r_hs  = m_axil_rvalid  & m_axil_rready;
         b_hs  = m_axil_bvalid  & m_axil_bready;
         if (ar_hs) ara = m_axil_araddr;
         if (aw_hs) awa = m_axil_awaddr;
         if (w_hs) begin wd = m_axil_wdata; ws = m_axil_wstrb; end
         @(posedge aclk);
         #1;
         if (!aresetn) begin
            aw_got = 1'b0; w_got = 1'b0;
            m_axil_arready = 1'b1; m_axil_awready = 1'b0; m_axil_wready = 1'b1;
            m_axil_rvalid = 1'b0; m_axil_bvalid = 1'b0;
         end else begin
            if (ar_hs) begin
               m_axil_rvalid  = 1'b1;
               m_axil_rdata   = mem[ara[12:1]];
               m_axil_arready = 1'b0;
            end
            if (r_hs) begin m_axil_rvalid = 1'b0; m_axil_arready = 1'b1; end
            if (w_hs) begin w_got = 1'b1; m_axil_wready = 1'b0; m_axil_awready = 1'b1; end
            if (aw_hs) begin aw_got = 1'b1; m_axil_awready = 1'b0; end
            if (aw_got && w_got) begin
               if (ws[0]) mem[awa[12:1]][7:0]  = wd[7:0];
               if (ws[1]) mem[awa[12:1]][15:8] = wd[15:8];
               m_axil_bvalid = 1'b1;
               aw_got = 1'b0; w_got = 1'b0;
            end
            if (b_hs) begin m_axil_bvalid = 1'b0; m_axil_wready = 1'b1; end
         end
      end
   end

   task automatic do_read(input int m, input logic [31:0] addr);
      int n;
      s_axil_araddr[m] = addr; s_axil_arprot[m] = 3'b000;
      s_axil_arvalid[m] = 1'b1; s_axil_rready[m] = 1'b1;
      n = 0;
      while (1) begin
         @(negedge aclk);
         if (s_axil_arready[m]) break;
         n++;
         if (n > 60) begin fail_now("ar_handshake_timeout"); break; end
      end
      @(posedge aclk); #1;
      s_axil_arvalid[m] = 1'b0;
      n = 0;
      while (1) begin
         @(negedge aclk);
         if (s_axil_rvalid[m]) break;
         n++;
         if (n > 60) begin fail_now("r_handshake_timeout"); break; end
      end
      @(posedge aclk); #1;
   endtask

   task automatic do_write(input int m, input logic [31:0] addr, input logic [15:0] data);
      int   n;
      logic aw_p, w_p, a, w;
      s_axil_awaddr[m] = addr; s_axil_awprot[m] = 3'b000;
      s_axil_wdata[m] = data; s_axil_wstrb[m] = 2'b11;
      s_axil_awvalid[m] = 1'b1; s_axil_wvalid[m] = 1'b1; s_axil_bready[m] = 1'b1;
      aw_p = 1'b1; w_p = 1'b1; n = 0;
      while (aw_p || w_p) begin
         @(negedge aclk);
         a = s_axil_awready[m];
         w = s_axil_wready[m];
         @(posedge aclk); #1;
         if (a) begin s_axil_awvalid[m] = 1'b0; aw_p = 1'b0; end
         if (w) begin s_axil_wvalid[m] = 1'b0; w_p = 1'b0; end
         n++;
         if (n > 60) begin
            fail_now("aw_w_handshake_timeout");
            s_axil_awvalid[m] = 1'b0; s_axil_wvalid[m] = 1'b0;
            aw_p = 1'b0; w_p = 1'b0;
         end
      end
      n = 0;
      while (1) begin
         @(negedge aclk);
         if (s_axil_bvalid[m]) break;
         n++;
         if (n > 60) begin fail_now("b_handshake_timeout"); break; end
      end
      @(posedge aclk); #1;
   endtask

   task automatic do_reset();
      @(posedge aclk); #1;
      aresetn = 1'b0;
      s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = '0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = '0; s_axil_bready = '0;
      s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = '0; s_axil_rready = '0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset state and quiet release
      s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = '0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = '0; s_axil_bready = '0;
      s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = '0; s_axil_rready = '0;
      @(negedge aclk);
      chk("reset_outputs_zero", 32'(all_ctrl_outs()), 32'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         chk("idle_no_arvalid", 32'(m_axil_arvalid), 32'd0);
      end
      @(posedge aclk); #1;

      // 2: single read, AR forwarded one cycle after the request
      q_ar.push_back(mk(0, 32'h100, 16'h0));
      q_r.push_back(mk(0, 32'h100, 16'hBEEF));
      q_done.push_back(mk(0, 32'd0, 16'h0));
      fork
         do_read(0, 32'h100);
         begin
            @(negedge aclk);
            chk("t2_arvalid_req_cycle", 32'(m_axil_arvalid), 32'd0);
            @(negedge aclk);
            chk("t2_arvalid_next_cycle", 32'(m_axil_arvalid), 32'd1);
            chk("t2_araddr", m_axil_araddr, 32'h100);
            repeat (3) begin
               @(negedge aclk);
               chk("t2_rvalid_m1_low", 32'(s_axil_rvalid[1]), 32'd0);
            end
         end
      join

      // 3: continuous reads from both masters alternate with one idle bubble
      do_reset();
      ar_cyc.delete();
      q_ar.push_back(mk(0, 32'h300, 16'h0)); q_r.push_back(mk(0, 32'h300, pat(32'h300)));
      q_ar.push_back(mk(1, 32'h400, 16'h0)); q_r.push_back(mk(1, 32'h400, pat(32'h400)));
      q_ar.push_back(mk(0, 32'h302, 16'h0)); q_r.push_back(mk(0, 32'h302, pat(32'h302)));
      q_ar.push_back(mk(1, 32'h402, 16'h0)); q_r.push_back(mk(1, 32'h402, pat(32'h402)));
      q_done.push_back(mk(0, 32'd0, 16'h0)); q_done.push_back(mk(1, 32'd0, 16'h0));
      q_done.push_back(mk(0, 32'd0, 16'h0)); q_done.push_back(mk(1, 32'd0, 16'h0));
      fork
         begin do_read(0, 32'h300); do_read(0, 32'h302); end
         begin do_read(1, 32'h400); do_read(1, 32'h402); end
      join
      chk("t3_ar_count", 32'(ar_cyc.size()), 32'd4);
      // AR accepted, R next cycle, one IDLE cycle, then the next AR: 3 cycles apart.
      for (int i = 1; i < ar_cyc.size(); i++)
         chk("t3_ar_spacing", 32'(ar_cyc[i] - ar_cyc[i-1]), 32'd3);

      // 4: write with W accepted before AW, then read back
      q_aw.push_back(mk(1, 32'h20, 16'h0));
      q_w.push_back(mk(1, 32'h0, 16'h1234));
      q_done.push_back(mk(1, 32'd1, 16'h0));
      do_write(1, 32'h20, 16'h1234);
      chk("t4_w_before_aw", 32'(last_w_cyc < last_aw_cyc), 32'd1);
      q_ar.push_back(mk(0, 32'h20, 16'h0));
      q_r.push_back(mk(0, 32'h20, 16'h1234));
      q_done.push_back(mk(0, 32'd0, 16'h0));
      do_read(0, 32'h20);

      // 5: M0 read+write and M1 write pending -> M0 read, M1 write, M0 write
      do_reset();
      q_ar.push_back(mk(0, 32'h200, 16'h0));
      q_r.push_back(mk(0, 32'h200, pat(32'h200)));
      q_aw.push_back(mk(1, 32'h30, 16'h0)); q_w.push_back(mk(1, 32'h0, 16'h5555));
      q_aw.push_back(mk(0, 32'h32, 16'h0)); q_w.push_back(mk(0, 32'h0, 16'h6666));
      q_done.push_back(mk(0, 32'd0, 16'h0));
      q_done.push_back(mk(1, 32'd1, 16'h0));
      q_done.push_back(mk(0, 32'd1, 16'h0));
      fork
         do_read(0, 32'h200);
         do_write(0, 32'h32, 16'h6666);
         do_write(1, 32'h30, 16'h5555);
      join
      q_ar.push_back(mk(1, 32'h32, 16'h0));
      q_r.push_back(mk(1, 32'h32, 16'h6666));
      q_done.push_back(mk(1, 32'd0, 16'h0));
      do_read(1, 32'h32);

      // 6: reset during RD_DATA clears outputs and restores M0 priority
      q_ar.push_back(mk(0, 32'h40, 16'h0));
      q_r.push_back(mk(0, 32'h40, pat(32'h40)));
      q_done.push_back(mk(0, 32'd0, 16'h0));
      do_read(0, 32'h40);
      q_ar.push_back(mk(1, 32'h42, 16'h0));
      s_axil_araddr[1] = 32'h42; s_axil_arvalid[1] = 1'b1; s_axil_rready[1] = 1'b0;
      begin
         int n;
         n = 0;
         while (1) begin
            @(negedge aclk);
            if (s_axil_arready[1]) break;
            n++;
            if (n > 60) begin fail_now("t6_ar_timeout"); break; end
         end
      end
      @(posedge aclk); #1;
      s_axil_arvalid[1] = 1'b0;
      @(negedge aclk);
      chk("t6_rvalid_before_reset", 32'(s_axil_rvalid[1]), 32'd1);
      #2;
      aresetn = 1'b0;
      #1;
      chk("t6_async_reset_outputs", 32'(all_ctrl_outs()), 32'd0);
      repeat (2) @(posedge aclk);
      #1;
      s_axil_rready[1] = 1'b1;
      aresetn = 1'b1;
      q_ar.push_back(mk(0, 32'h46, 16'h0)); q_r.push_back(mk(0, 32'h46, pat(32'h46)));
      q_ar.push_back(mk(1, 32'h44, 16'h0)); q_r.push_back(mk(1, 32'h44, pat(32'h44)));
      q_done.push_back(mk(0, 32'd0, 16'h0));
      q_done.push_back(mk(1, 32'd0, 16'h0));
      fork
         do_read(1, 32'h44);
         do_read(0, 32'h46);
      join

      repeat (4) @(negedge aclk);
      chk("q_ar_drained", 32'(q_ar.size()), 32'd0);
      chk("q_aw_drained", 32'(q_aw.size()), 32'd0);
      chk("q_w_drained", 32'(q_w.size()), 32'd0);
      chk("q_r_drained", 32'(q_r.size()), 32'd0);
      chk("q_done_drained", 32'(q_done.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
